// File: rtl/pass_counter_pkg.sv
// pass_counter_pkg
//   Shared definitions for the occupancy counter: the per-channel FSM state
//   encoding and a population-count helper used by the count merge.
package pass_counter_pkg;

    // Encoding 3'd7 is unused; the detector treats it as IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_A_FIRST  = 3'd1,
        ST_B_FIRST  = 3'd2,
        ST_INC      = 3'd3,
        ST_DEC      = 3'd4,
        ST_GLITCH   = 3'd5,
        ST_WAIT_CLR = 3'd6
    } state_t;

    // Widest channel vector the helper accepts (N_CH is limited to 1..8).
    localparam int MAX_CH = 8;

    function automatic logic [3:0] popcount(input logic [MAX_CH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/pass_counter_if.sv
// pass_counter_if
//   Sensor inputs, clear, per-channel pulses and merged status of the
//   occupancy counter.
//   master: drives sensor_a/sensor_b/clear, observes everything else.
//   slave : the counter itself.
interface pass_counter_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]  sensor_a;
    logic [N_CH-1:0]  sensor_b;
    logic             clear;
    logic [N_CH-1:0]  inc_pulse;
    logic [N_CH-1:0]  dec_pulse;
    logic [N_CH-1:0]  glitch;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output sensor_a, sensor_b, clear,
        input  inc_pulse, dec_pulse, glitch, count, full, empty, overflow, underflow
    );

    modport slave (
        input  sensor_a, sensor_b, clear,
        output inc_pulse, dec_pulse, glitch, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/pass_counter_detector.sv
// pass_detector
//   One sensor-pair channel: classifies a pass by which sensor rises first.
//   Ports:
//     i_clk, i_rst_n      clock, async active-low reset
//     i_a, i_b            outer / inner sensor (already synchronised)
//     o_inc, o_dec        one-cycle entry / exit pulse
//     o_glitch            one-cycle pulse when both sensors rose together
//   Outputs are pure state decodes, so there is no path from the sensors.
module pass_detector
    import pass_counter_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_a,
    input  logic i_b,
    output logic o_inc,
    output logic o_dec,
    output logic o_glitch
);
    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic [TW-1:0] r_timer;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A/B_FIRST are only entered from here, so zeroing the
                    // timer while idle clears it on every entry.
                    r_timer <= '0;
                    if (i_a && !i_b)      r_state <= ST_A_FIRST;
                    else if (i_b && !i_a) r_state <= ST_B_FIRST;
                    else if (i_a && i_b)  r_state <= ST_GLITCH;
                end
                ST_A_FIRST: begin
                    if (i_b)                    r_state <= ST_INC;
                    else if (r_timer == T_LAST) r_state <= ST_WAIT_CLR;
                    else                        r_timer <= r_timer + TW'(1);
                end
                ST_B_FIRST: begin
                    if (i_a)                    r_state <= ST_DEC;
                    else if (r_timer == T_LAST) r_state <= ST_WAIT_CLR;
                    else                        r_timer <= r_timer + TW'(1);
                end
                ST_INC, ST_DEC, ST_GLITCH: r_state <= ST_WAIT_CLR;
                // Hold here while either sensor is still covered so a long
                // occlusion cannot retrigger.
                ST_WAIT_CLR: if (!i_a && !i_b) r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_inc    = (r_state == ST_INC);
    assign o_dec    = (r_state == ST_DEC);
    assign o_glitch = (r_state == ST_GLITCH);

endmodule

// File: rtl/pass_counter.sv
// pass_counter
//   Multi-channel occupancy counter. N_CH pass detectors feed a single
//   saturating count with full/empty status and sticky over/underflow.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     bus (slave)  sensor_a/sensor_b/clear in; inc_pulse/dec_pulse/glitch,
//                  count, full, empty, overflow, underflow out
module pass_counter
    import pass_counter_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 200,
    parameter int TIMEOUT   = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    pass_counter_if.slave  bus
);
    localparam int DW = $clog2(N_CH + 1) + 1;

    logic [N_CH-1:0]     w_inc;
    logic [N_CH-1:0]     w_dec;
    logic [N_CH-1:0]     w_gl;
    logic [3:0]          w_n_inc;
    logic [3:0]          w_n_dec;
    logic signed [DW-1:0] w_delta;
    int                  w_next;

    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_unf;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            pass_detector #(.TIMEOUT(TIMEOUT)) u_det (
                .i_clk    (clk),
                .i_rst_n  (rst_n),
                .i_a      (bus.sensor_a[g]),
                .i_b      (bus.sensor_b[g]),
                .o_inc    (w_inc[g]),
                .o_dec    (w_dec[g]),
                .o_glitch (w_gl[g])
            );
        end
    endgenerate

    // Opposite-direction pulses net out before saturation is applied.
    assign w_n_inc = popcount(MAX_CH'(w_inc));
    assign w_n_dec = popcount(MAX_CH'(w_dec));
    assign w_delta = DW'(int'(w_n_inc) - int'(w_n_dec));
    assign w_next  = int'(r_count) + int'(w_delta);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (bus.clear) begin
            // Clear wins and drops this cycle's delta.
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_next > MAX_COUNT) begin
            r_count <= CNT_W'(MAX_COUNT);
            r_ovf   <= 1'b1;
        end else if (w_next < 0) begin
            r_count <= '0;
            r_unf   <= 1'b1;
        end else begin
            r_count <= CNT_W'(w_next);
        end
    end

    assign bus.inc_pulse = w_inc;
    assign bus.dec_pulse = w_dec;
    assign bus.glitch    = w_gl;
    assign bus.count     = r_count;
    assign bus.full      = (r_count == CNT_W'(MAX_COUNT));
    assign bus.empty     = (r_count == '0);
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;

endmodule
